// File: rtl/lv_owt_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lv_owt_tx_ctrl_pkg
// Shared constants for the LV one-wire (OWT) transmit and receive controllers:
// field widths, half-bit timing, CRC-8 polynomial, FSM state encoding and a
// few helpers that describe the shape of each frame field.
// LV_OWT_TX_GAP_EN adds the GAP state to the encoding.
// ---------------------------------------------------------------------------
package lv_owt_tx_ctrl_pkg;

    localparam int OWT_EXT_CYC_NUM  = 32;
    localparam int OWT_SYNC_BIT_NUM = 12;
    localparam int OWT_TAIL_BIT_NUM = 4;
    localparam int OWT_CMD_BIT_NUM  = 8;
    localparam int OWT_DATA_BIT_NUM = 8;
    localparam int OWT_CRC_BIT_NUM  = 8;
    localparam int OWT_GAP_CYC_NUM  = 64;

    localparam logic [OWT_CRC_BIT_NUM-1:0] OWT_CRC_POLY = 8'h07;

    // One cycle counter serves both half-bit timing and the inter-frame gap.
    localparam int OWT_CYC_CNT_W = $clog2((OWT_GAP_CYC_NUM > OWT_EXT_CYC_NUM) ?
                                          OWT_GAP_CYC_NUM : OWT_EXT_CYC_NUM);
    // The sync head is the longest field.
    localparam int OWT_BIT_CNT_W = $clog2(OWT_SYNC_BIT_NUM);
    // Cmd, data and CRC share one width, so one bit index fits all three.
    localparam int OWT_BIT_IDX_W = $clog2(OWT_CMD_BIT_NUM);

    localparam int OWT_FSM_ST_W = 3;

    typedef enum logic [OWT_FSM_ST_W-1:0] {
        OWT_ST_IDLE      = 3'd0,
        OWT_ST_SYNC_HEAD = 3'd1,
        OWT_ST_SYNC_TAIL = 3'd2,
        OWT_ST_CMD       = 3'd3,
        OWT_ST_DATA      = 3'd4,
        OWT_ST_CRC       = 3'd5,
        OWT_ST_END_TAIL  = 3'd6
`ifdef LV_OWT_TX_GAP_EN
        , OWT_ST_GAP     = 3'd7
`endif
    } owt_tx_st_e;

    // Index of the last bit (or raw symbol) in a field.
    function automatic logic [OWT_BIT_CNT_W-1:0] owt_field_last(input owt_tx_st_e st);
        case (st)
            OWT_ST_SYNC_HEAD:                  return OWT_BIT_CNT_W'(OWT_SYNC_BIT_NUM - 1);
            OWT_ST_SYNC_TAIL, OWT_ST_END_TAIL: return OWT_BIT_CNT_W'(OWT_TAIL_BIT_NUM - 1);
            OWT_ST_CMD:                        return OWT_BIT_CNT_W'(OWT_CMD_BIT_NUM - 1);
            OWT_ST_DATA:                       return OWT_BIT_CNT_W'(OWT_DATA_BIT_NUM - 1);
            OWT_ST_CRC:                        return OWT_BIT_CNT_W'(OWT_CRC_BIT_NUM - 1);
            default:                           return '0;
        endcase
    endfunction

    // Tail fields are raw half-bit symbols rather than Manchester bits.
    function automatic logic owt_is_tail(input owt_tx_st_e st);
        return (st == OWT_ST_SYNC_TAIL) || (st == OWT_ST_END_TAIL);
    endfunction

    // Fields go out MSB first: bit counter 0 selects the top bit.
    function automatic logic [OWT_BIT_IDX_W-1:0] owt_msb_idx(input logic [OWT_BIT_CNT_W-1:0] bit_cnt);
        return OWT_BIT_IDX_W'(OWT_CMD_BIT_NUM - 1) - bit_cnt[OWT_BIT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/lv_owt_tx_ctrl_crc8_serial.sv
// ---------------------------------------------------------------------------
// crc8_serial
// Bit-serial CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_vld            fold i_data into the CRC this cycle
//   i_data           message bit, MSB of the message first
//   i_new_calc       restart the calculation (CRC cleared to 0)
//   o_vld_crc        running CRC value
// ---------------------------------------------------------------------------
module crc8_serial
    import lv_owt_tx_ctrl_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_vld,
    input  logic                       i_data,
    input  logic                       i_new_calc,
    output logic [OWT_CRC_BIT_NUM-1:0] o_vld_crc
);

    logic feedback;

    assign feedback = o_vld_crc[OWT_CRC_BIT_NUM-1] ^ i_data;

    // Restart has priority so a new frame never inherits the old CRC.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld_crc <= '0;
        end else if (i_new_calc) begin
            o_vld_crc <= '0;
        end else if (i_vld) begin
            o_vld_crc <= {o_vld_crc[OWT_CRC_BIT_NUM-2:0], 1'b0} ^
                         ({OWT_CRC_BIT_NUM{feedback}} & OWT_CRC_POLY);
        end
    end

endmodule

// File: rtl/lv_owt_tx_ctrl.sv
// ---------------------------------------------------------------------------
// lv_owt_tx_ctrl
// LV-side one-wire frame transmitter. Frame: sync head (12 Manchester-0 bits),
// sync tail (raw 1100), cmd, data, CRC-8 (Manchester, MSB first), end tail
// (raw 1100). Each half-bit lasts OWT_EXT_CYC_NUM cycles. Line idles low.
// Optional macro LV_OWT_TX_GAP_EN: hold the line low and busy high for
// OWT_GAP_CYC_NUM cycles after each frame.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_owt_tx_req        frame request, only acted on while idle
//   i_owt_tx_cmd/data   frame payload, latched on acceptance
//   o_owt_tx_busy       frame (or gap) in progress
//   o_owt_tx_done       one-cycle pulse after the end tail
//   o_owt_tx_cmd_lock   command of the last accepted frame (for rx matching)
//   o_lv_hv_owt_tx      registered one-wire line
// ---------------------------------------------------------------------------
module lv_owt_tx_ctrl
    import lv_owt_tx_ctrl_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_owt_tx_req,
    input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
    input  logic [OWT_DATA_BIT_NUM-1:0] i_owt_tx_data,
    output logic                        o_owt_tx_busy,
    output logic                        o_owt_tx_done,
    output logic [OWT_CMD_BIT_NUM-1:0]  o_owt_tx_cmd_lock,
    output logic                        o_lv_hv_owt_tx
);

    localparam logic [OWT_CYC_CNT_W-1:0] HALF_LAST = OWT_CYC_CNT_W'(OWT_EXT_CYC_NUM - 1);
`ifdef LV_OWT_TX_GAP_EN
    localparam logic [OWT_CYC_CNT_W-1:0] GAP_LAST  = OWT_CYC_CNT_W'(OWT_GAP_CYC_NUM - 1);
`endif

    owt_tx_st_e                  st_q, st_d;
    logic [OWT_CYC_CNT_W-1:0]    cyc_q, cyc_d;
    logic                        half_q, half_d;
    logic [OWT_BIT_CNT_W-1:0]    bit_q, bit_d;
    logic [OWT_DATA_BIT_NUM-1:0] data_q;
    logic [OWT_CRC_BIT_NUM-1:0]  crc;
    logic                        accept, crc_vld, crc_bit, done_d, line_d;

    assign o_owt_tx_busy = (st_q != OWT_ST_IDLE);

    // Next-state logic: the cycle counter times each half-bit; Manchester
    // fields advance the bit counter every second half, tail fields every half.
    // A CRC update is issued as each cmd/data bit is launched.
    always_comb begin
        st_d    = st_q;
        cyc_d   = cyc_q;
        half_d  = half_q;
        bit_d   = bit_q;
        accept  = 1'b0;
        done_d  = 1'b0;
        crc_vld = 1'b0;
        crc_bit = 1'b0;
        case (st_q)
            OWT_ST_IDLE: begin
                if (i_owt_tx_req) begin
                    accept = 1'b1;
                    st_d   = OWT_ST_SYNC_HEAD;
                    cyc_d  = '0;
                    half_d = 1'b0;
                    bit_d  = '0;
                end
            end
`ifdef LV_OWT_TX_GAP_EN
            OWT_ST_GAP: begin
                if (cyc_q == GAP_LAST) begin
                    st_d  = OWT_ST_IDLE;
                    cyc_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
`endif
            default: begin
                if ((st_q == OWT_ST_CMD || st_q == OWT_ST_DATA) && cyc_q == '0 && !half_q) begin
                    crc_vld = 1'b1;
                    crc_bit = (st_q == OWT_ST_CMD) ? o_owt_tx_cmd_lock[owt_msb_idx(bit_q)]
                                                   : data_q[owt_msb_idx(bit_q)];
                end
                if (cyc_q == HALF_LAST) begin
                    cyc_d = '0;
                    if (owt_is_tail(st_q) || half_q) begin
                        half_d = 1'b0;
                        if (bit_q == owt_field_last(st_q)) begin
                            bit_d = '0;
                            case (st_q)
                                OWT_ST_SYNC_HEAD: st_d = OWT_ST_SYNC_TAIL;
                                OWT_ST_SYNC_TAIL: st_d = OWT_ST_CMD;
                                OWT_ST_CMD:       st_d = OWT_ST_DATA;
                                OWT_ST_DATA:      st_d = OWT_ST_CRC;
                                OWT_ST_CRC:       st_d = OWT_ST_END_TAIL;
                                default: begin
                                    done_d = 1'b1;
`ifdef LV_OWT_TX_GAP_EN
                                    st_d   = OWT_ST_GAP;
`else
                                    st_d   = OWT_ST_IDLE;
`endif
                                end
                            endcase
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        half_d = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
        endcase
    end

    // Line level for the coming cycle, derived from the next state so that the
    // registered output lines up with the field it belongs to. Manchester bit b
    // sends b in the first half and ~b in the second.
    always_comb begin
        line_d = 1'b0;
        case (st_d)
            OWT_ST_SYNC_HEAD: line_d = half_d;
            OWT_ST_SYNC_TAIL,
            OWT_ST_END_TAIL:  line_d = ~bit_d[1];
            OWT_ST_CMD:       line_d = o_owt_tx_cmd_lock[owt_msb_idx(bit_d)] ^ half_d;
            OWT_ST_DATA:      line_d = data_q[owt_msb_idx(bit_d)] ^ half_d;
            OWT_ST_CRC:       line_d = crc[owt_msb_idx(bit_d)] ^ half_d;
            default:          line_d = 1'b0;
        endcase
    end

    // State, counters, latched payload and registered outputs. The latched
    // command doubles as the lock output for the receive controller.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q              <= OWT_ST_IDLE;
            cyc_q             <= '0;
            half_q            <= 1'b0;
            bit_q             <= '0;
            data_q            <= '0;
            o_owt_tx_cmd_lock <= '0;
            o_owt_tx_done     <= 1'b0;
            o_lv_hv_owt_tx    <= 1'b0;
        end else begin
            st_q           <= st_d;
            cyc_q          <= cyc_d;
            half_q         <= half_d;
            bit_q          <= bit_d;
            o_owt_tx_done  <= done_d;
            o_lv_hv_owt_tx <= line_d;
            if (accept) begin
                data_q            <= i_owt_tx_data;
                o_owt_tx_cmd_lock <= i_owt_tx_cmd;
            end
        end
    end

    crc8_serial u_crc8_serial (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_vld      (crc_vld),
        .i_data     (crc_bit),
        .i_new_calc (accept),
        .o_vld_crc  (crc)
    );

endmodule

// File: tb/tb_lv_owt_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lv_owt_tx_ctrl
// Directed bench for lv_owt_tx_ctrl. A frame-level model (expected half-bit
// list per accepted frame, position counter, gap counter) predicts every
// output each cycle; captured frames are also decoded field by field and
// checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_lv_owt_tx_ctrl;

    localparam int H         = 32;
    localparam int N_HALVES  = 80;
    localparam int FRAME_CYC = H * N_HALVES;
`ifdef LV_OWT_TX_GAP_EN
    localparam int GAP       = 64;
`else
    localparam int GAP       = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic [7:0] data = 8'h00;
    logic       busy, done, line;
    logic [7:0] lock;

    lv_owt_tx_ctrl dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_owt_tx_req      (req),
        .i_owt_tx_cmd      (cmd),
        .i_owt_tx_data     (data),
        .o_owt_tx_busy     (busy),
        .o_owt_tx_done     (done),
        .o_owt_tx_cmd_lock (lock),
        .o_lv_hv_owt_tx    (line)
    );

    always #5 i_clk = ~i_clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [7:0] c, input logic [7:0] d);
        @(posedge i_clk);
        #1;
        req  = r;
        cmd  = c;
        data = d;
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [15:0] msg;
        logic [7:0]  r;
        logic        fb;
        msg = {c, d};
        r   = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = r[7] ^ msg[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    function automatic logic [N_HALVES-1:0] frameHalves(input logic [7:0] c, input logic [7:0] d);
        logic [N_HALVES-1:0] h;
        logic [23:0]         pay;
        int                  k;
        h   = '0;
        pay = {c, d, crc8(c, d)};
        k   = 0;
        for (int i = 0; i < 12; i++) begin
            h[k] = 1'b0; h[k+1] = 1'b1; k += 2;
        end
        h[k] = 1'b1; h[k+1] = 1'b1; h[k+2] = 1'b0; h[k+3] = 1'b0; k += 4;
        for (int i = 23; i >= 0; i--) begin
            h[k] = pay[i]; h[k+1] = ~pay[i]; k += 2;
        end
        h[k] = 1'b1; h[k+1] = 1'b1; h[k+2] = 1'b0; h[k+3] = 1'b0;
        return h;
    endfunction

    // Frame-level model: position within the current frame (-1 when none),
    // remaining gap cycles, expected done/lock.
    int                  m_pos = -1;
    int                  m_gap = 0;
    logic                m_done = 1'b0;
    logic [7:0]          m_lock = 8'h00;
    logic [N_HALVES-1:0] m_halves = '0;

    initial forever begin
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            m_pos  = -1;
            m_gap  = 0;
            m_done = 1'b0;
            m_lock = 8'h00;
        end else begin
            m_done = 1'b0;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FRAME_CYC) begin
                    m_pos  = -1;
                    m_done = 1'b1;
                    m_gap  = GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req) begin
                m_pos    = 0;
                m_lock   = cmd;
                m_halves = frameHalves(cmd, data);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge i_clk);
        checkOutput("line", {31'd0, line}, {31'd0, (m_pos >= 0) ? m_halves[m_pos / H] : 1'b0});
        checkOutput("busy", {31'd0, busy}, {31'd0, (m_pos >= 0) || (m_gap > 0)});
        checkOutput("done", {31'd0, done}, {31'd0, m_done});
        checkOutput("cmd_lock", {24'd0, lock}, {24'd0, m_lock});
    end

    // Frame capture for field decoding, plus busy-rise and done timestamps.
    logic cap_q[$];
    logic last_frame[$];
    int   frames_seen = 0;
    int   last_done_cyc = 0;
    int   rises = 0;
    int   last_rise_cyc = 0;
    logic prev_busy = 1'b0;
    logic in_gap = 1'b0;

    initial forever begin
        @(negedge i_clk);
        if (!i_rst_n) begin
            cap_q.delete();
            in_gap    = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                rises++;
                last_rise_cyc = cyc;
            end
            prev_busy = busy;
            if (done) begin
                last_frame = cap_q;
                frames_seen++;
                last_done_cyc = cyc;
                cap_q.delete();
                in_gap = busy;
            end else if (in_gap) begin
                if (!busy) in_gap = 1'b0;
            end else if (busy) begin
                cap_q.push_back(line);
            end
        end
    end

    task automatic waitFrame();
        int start;
        start = frames_seen;
        for (int i = 0; i < FRAME_CYC + 1000; i++) begin
            @(negedge i_clk);
            #1;
            if (frames_seen != start) break;
        end
        checkOutput("frame_done_seen", {31'd0, frames_seen != start}, 32'd1);
    endtask

    task automatic checkFrame(input logic [7:0] ec, input logic [7:0] ed, input logic [7:0] ecrc);
        logic h[N_HALVES];
        int   bad, serr, merr;
        logic [7:0] dc, dd, dcrc;
        logic [3:0] t1, t2;
        checkOutput("frame_len", last_frame.size(), FRAME_CYC);
        if (last_frame.size() != FRAME_CYC) return;
        bad = 0;
        for (int k = 0; k < N_HALVES; k++) begin
            h[k] = last_frame[k*H];
            for (int j = 1; j < H; j++)
                if (last_frame[k*H+j] !== h[k]) bad++;
        end
        checkOutput("half_uniform", bad, 0);
        serr = 0;
        for (int i = 0; i < 12; i++)
            if (!(h[2*i] == 1'b0 && h[2*i+1] == 1'b1)) serr++;
        checkOutput("sync_head", serr, 0);
        t1 = {h[24], h[25], h[26], h[27]};
        t2 = {h[76], h[77], h[78], h[79]};
        checkOutput("sync_tail", {28'd0, t1}, 32'hC);
        checkOutput("end_tail", {28'd0, t2}, 32'hC);
        merr = 0;
        for (int i = 0; i < 8; i++) begin
            dc[7-i]   = h[28 + 2*i];
            dd[7-i]   = h[44 + 2*i];
            dcrc[7-i] = h[60 + 2*i];
            if (h[29 + 2*i] == h[28 + 2*i]) merr++;
            if (h[45 + 2*i] == h[44 + 2*i]) merr++;
            if (h[61 + 2*i] == h[60 + 2*i]) merr++;
        end
        checkOutput("manchester", merr, 0);
        checkOutput("cmd_field", {24'd0, dc}, {24'd0, ec});
        checkOutput("data_field", {24'd0, dd}, {24'd0, ed});
        checkOutput("crc_field", {24'd0, dcrc}, {24'd0, ecrc});
    endtask

    initial begin
        #2_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: bench did not finish, compared %0d", compared);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d, r;
        repeat (3) applyStimulus(1'b0, 8'h00, 8'h00);
        @(posedge i_clk);
        #2 i_rst_n = 1'b1;

        // Reset state and quiet idle
        @(negedge i_clk);
        checkOutput("rst_line", {31'd0, line}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_lock", {24'd0, lock}, 32'd0);
        repeat (40) applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_line", {31'd0, line}, 32'd0);

        // Frame 0x85/0x3C, plus an ignored request mid-frame
        checkOutput("model_crc_pin", {24'd0, crc8(8'h85, 8'h3C)}, 32'h43);
        applyStimulus(1'b1, 8'h85, 8'h3C);
        checkOutput("accept_cycle_busy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 8'h85, 8'h3C);
        checkOutput("first_half_busy", {31'd0, busy}, 32'd1);
        checkOutput("first_half_line", {31'd0, line}, 32'd0);
        repeat (1000) applyStimulus(1'b0, 8'h85, 8'h3C);
        repeat (5) applyStimulus(1'b1, 8'h12, 8'hFF);
        applyStimulus(1'b0, 8'h12, 8'hFF);
        checkOutput("lock_mid_req", {24'd0, lock}, 32'h85);
        waitFrame();
        checkFrame(8'h85, 8'h3C, 8'h43);
        checkOutput("lock_after", {24'd0, lock}, 32'h85);

        // All-zero payload
        repeat (GAP + 10) applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h00, 8'h00);
        applyStimulus(1'b0, 8'h00, 8'h00);
        waitFrame();
        checkFrame(8'h00, 8'h00, 8'h00);

        // Request held high: back-to-back frames
        repeat (GAP + 10) applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'hA5, 8'h5A);
        waitFrame();
        checkFrame(8'hA5, 8'h5A, crc8(8'hA5, 8'h5A));
        d = last_done_cyc;
        r = rises;
        for (int i = 0; i < 200 && rises == r; i++) @(negedge i_clk);
        checkOutput("b2b_restart_seen", {31'd0, rises != r}, 32'd1);
        checkOutput("b2b_restart_delay", last_rise_cyc - d, (GAP > 0) ? GAP + 1 : 1);
        applyStimulus(1'b0, 8'hA5, 8'h5A);
        waitFrame();
        checkFrame(8'hA5, 8'h5A, crc8(8'hA5, 8'h5A));

        // Reset pulse during the command field, then a fresh frame
        repeat (GAP + 10) applyStimulus(1'b0, 8'h00, 8'h00);
        applyStimulus(1'b1, 8'h85, 8'h3C);
        applyStimulus(1'b0, 8'h85, 8'h3C);
        repeat (1000) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_line", {31'd0, line}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_lock", {24'd0, lock}, 32'd0);
        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, 8'h00, 8'h00);
        checkOutput("post_rst_idle", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 8'h3C, 8'h85);
        applyStimulus(1'b0, 8'h3C, 8'h85);
        waitFrame();
        checkFrame(8'h3C, 8'h85, crc8(8'h3C, 8'h85));
        checkOutput("lock_fresh", {24'd0, lock}, 32'h3C);

        repeat (GAP + 20) applyStimulus(1'b0, 8'h00, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lv_owt_tx_ctrl.md
# lv_owt_tx_ctrl

LV-side one-wire (OWT) frame transmitter: accepts a command/data request from the LV register/control logic and serialises it onto the LV→HV one-wire line. The frame is sync head, sync tail, command, data, CRC-8 and end tail, with Manchester-coded payload. It is the transmit counterpart of the LV OWT receive controller and supplies it the locked command for response matching.

## Interface
- OWT_EXT_CYC_NUM, 32, clock cycles per half-bit (H)
- OWT_SYNC_BIT_NUM, 12, Manchester-0 bits in sync head
- OWT_TAIL_BIT_NUM, 4, raw half-bit symbols in sync/end tail
- OWT_CMD_BIT_NUM, 8, command width; MSB=1 write, 0 read
- OWT_DATA_BIT_NUM, 8, data width
- OWT_CRC_BIT_NUM, 8, CRC width
- OWT_GAP_CYC_NUM, 64, minimum inter-frame idle cycles (used only with LV_OWT_TX_GAP_EN)
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_owt_tx_req  input  1  frame request, sampled in IDLE only
- i_owt_tx_cmd  input  OWT_CMD_BIT_NUM  command
- i_owt_tx_data  input  OWT_DATA_BIT_NUM  data (don't-care content for reads, still transmitted)
- o_owt_tx_busy  output  1  frame in progress (or gap pending)
- o_owt_tx_done  output  1  one-cycle pulse at frame end
- o_owt_tx_cmd_lock  output  OWT_CMD_BIT_NUM  command of last accepted frame
- o_lv_hv_owt_tx  output  1  one-wire line, registered

## Operation
- Reset values: o_lv_hv_owt_tx=0, o_owt_tx_busy=0, o_owt_tx_done=0, o_owt_tx_cmd_lock=0; FSM in IDLE; line idle level is 0.
- FSM: IDLE → SYNC_HEAD → SYNC_TAIL → CMD → DATA → CRC → END_TAIL → (GAP) → IDLE. No error exits; a frame always completes.
- IDLE: i_owt_tx_req=1 accepts; cmd/data latched, cmd copied to o_owt_tx_cmd_lock, CRC cleared. Requests while busy are ignored (no queue).
- Manchester: bit 0 = low half then high half; bit 1 = high half then low half. Each half lasts exactly H cycles.
- SYNC_HEAD: OWT_SYNC_BIT_NUM Manchester-0 bits.
- SYNC_TAIL and END_TAIL: raw half-bit symbols 1,1,0,0 (H cycles each), not Manchester.
- CMD, DATA, CRC: MSB first.
- CRC-8: poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, computed serially over cmd bits then data bits as each bit is launched; CRC field sends the result MSB first.
- Counters: half-bit cycle counter 0..H-1, bit counter sized for largest field; both wrap to 0 at field end.

## Timing
- Request accepted in cycle N → busy=1 and first head half-bit on line from N+1.
- Frame length = (2·SYNC + 2·TAIL/2·... ) concretely (2·12 + 4 + 2·(8+8+8) + 4)·H = 80·H cycles (2560 at defaults).
- Line transitions occur only at half-bit boundaries; output is flop-driven, glitch-free.
- o_owt_tx_done pulses the cycle after the last END_TAIL half-bit ends; busy falls the same cycle (macro off). Earliest next acceptance is that same cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately; no partial-frame completion after release.
- o_owt_tx_cmd_lock holds until the next acceptance.

## Configuration
- LV_OWT_TX_GAP_EN defined: after END_TAIL the FSM enters GAP, line held 0, busy held 1 for OWT_GAP_CYC_NUM cycles; done still pulses at END_TAIL exit; requests during GAP ignored.
- Undefined: no GAP state; IDLE directly after END_TAIL.

## Structure
- State encoding (OWT_FSM_ST_W and state constants), field widths and CRC polynomial belong in the shared lv_param.svh include, shared with the OWT receive controller.
- Sub-module: reuse crc8_serial (i_vld, i_data, i_new_calc, o_vld_crc) for the CRC; no other hierarchy.

## Test plan
- Reset, no request → line 0, busy 0, done 0, cmd_lock 0 indefinitely.
- cmd=8'h85, data=8'h3C → decoded line yields 12×bit0, 1100, 0x85, 0x3C, CRC 0x43, 1100; total 2560 cycles; done single pulse.
- cmd=8'h00, data=8'h00 → CRC field 0x00; every half-bit measured exactly 32 cycles.
- Request held high continuously → back-to-back frames, second starting the cycle done pulses (macro off) or 64 cycles later (macro on).
- Second request with cmd=8'h12 mid-frame → ignored; cmd_lock stays at first command.
- Reset pulse in CMD field → line 0 next cycle, busy 0; new request after release sends complete fresh frame.
